// File: rtl/core_seq_rv_if.sv
// core_seq_rv_if: fetch/data-memory handshake and decode/execute control bundle for core_seq_rv
interface core_seq_rv_if;
  logic        iwHalt;
  logic        iwIMemReady;
  logic        iwDMemReady;
  logic [3:0]  iwException;
  logic        iwMemAccess;
  logic [31:0] iwNextPc;
  logic [31:0] orPc;
  logic [31:0] orOldPc;
  logic        orIMemReq;
  logic        orDMemReq;
  logic        orInstrLatch;
  logic        orRegWrite;
  logic        orTrap;
  logic [3:0]  orTrapCause;
  logic [2:0]  orState;
  logic [31:0] orInstret;
  modport master (
    input  iwHalt, iwIMemReady, iwDMemReady, iwException, iwMemAccess, iwNextPc,
    output orPc, orOldPc, orIMemReq, orDMemReq, orInstrLatch, orRegWrite, orTrap,
           orTrapCause, orState, orInstret
  );
  modport slave (
    output iwHalt, iwIMemReady, iwDMemReady, iwException, iwMemAccess, iwNextPc,
    input  orPc, orOldPc, orIMemReq, orDMemReq, orInstrLatch, orRegWrite, orTrap,
           orTrapCause, orState, orInstret
  );
endinterface

// File: rtl/core_seq_rv.sv
// core_seq_rv: multi-cycle RV32I sequencer with trap routing; CORE_SEQ_RV_INSTRET_EN builds the retire counter
module core_seq_rv #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100,
  parameter int          MEM_TIMEOUT = 16
) (
  input logic iwClk,
  input logic iwnRst,
  core_seq_rv_if.master bus
);
  localparam int CW = $clog2(MEM_TIMEOUT + 1);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
  state_t state;
  logic [31:0] pc, oldPc;
  logic [3:0] trapCause, pendCause;
  logic [CW-1:0] waitCnt;
  logic timeout, misaligned, retire;
  assign timeout = waitCnt == CW'(MEM_TIMEOUT - 1);
  assign misaligned = bus.iwNextPc[1:0] != 2'b00;
  assign retire = state == WB && !misaligned;
  assign bus.orIMemReq = state == FETCH && !bus.iwHalt;
  assign bus.orInstrLatch = bus.orIMemReq && bus.iwIMemReady;
  assign bus.orDMemReq = state == MEM;
  assign bus.orRegWrite = retire;
  assign bus.orTrap = state == TRAP;
  assign bus.orPc = pc;
  assign bus.orOldPc = oldPc;
  assign bus.orTrapCause = trapCause;
  assign bus.orState = state;
  // Counter defaults to zero so every entry into FETCH/MEM (and halt) starts a fresh wait
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) begin
      state <= FETCH;
      pc <= RESET_PC;
      oldPc <= '0;
      trapCause <= '0;
      pendCause <= '0;
      waitCnt <= '0;
    end else begin
      waitCnt <= '0;
      case (state)
        FETCH: if (!bus.iwHalt) begin
          if (bus.iwIMemReady) state <= DECODE;
          else if (timeout) begin
            state <= TRAP;
            pendCause <= 4'hF;
          end else waitCnt <= waitCnt + CW'(1);
        end
        DECODE: if (bus.iwException != 4'h0) begin
          state <= TRAP;
          pendCause <= bus.iwException;
        end else state <= EXEC;
        EXEC: state <= bus.iwMemAccess ? MEM : WB;
        MEM: if (bus.iwDMemReady) state <= WB;
        else if (timeout) begin
          state <= TRAP;
          pendCause <= 4'hF;
        end else waitCnt <= waitCnt + CW'(1);
        WB: if (misaligned) begin
          state <= TRAP;
          pendCause <= 4'hE;
        end else begin
          oldPc <= pc;
          pc <= bus.iwNextPc;
          state <= FETCH;
        end
        TRAP: begin
          oldPc <= pc;
          pc <= TRAP_VECTOR;
          trapCause <= pendCause;
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end
`ifdef CORE_SEQ_RV_INSTRET_EN
  logic [31:0] instret;
  always_ff @(posedge iwClk or negedge iwnRst) begin
    if (!iwnRst) instret <= '0;
    else if (retire) instret <= instret + 32'd1;
  end
  assign bus.orInstret = instret;
`else
  assign bus.orInstret = 32'h0;
`endif
endmodule
